// File: rtl/ahb2apb_pkg.sv
// Shared AHB-Lite encodings and bridge state type for the AHB-to-APB bridge.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } ahb2apb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // APB pprot = {instruction, non-secure, privileged}
  function automatic logic [2:0] ahb_to_apb_prot(input logic [6:0] hprot);
    return {~hprot[0], 1'b1, hprot[1]};
  endfunction

  function automatic logic size_supported(input logic [2:0] hsize);
    return hsize <= HSIZE_WORD;
  endfunction

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator for 32-bit AHB slaves: reads and oversized
// transfers produce no strobes.
module ahb_strb_gen
  import ahb2apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       write,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'h0;
    if (write) begin
      case (hsize)
        HSIZE_BYTE: strb = 4'b0001 << addr_lo;
        HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
        HSIZE_WORD: strb = 4'hF;
        default:    strb = 4'h0;
      endcase
    end
  end

endmodule

// File: rtl/ahb2apb.sv
// AHB-Lite slave to APB4 master bridge: one transfer in flight, all outputs
// registered, read data and slave errors returned as AHB responses.
module ahb2apb
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [6:0]        hprot,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [3:0]        pstrb,
  output logic [2:0]        pprot,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  ahb2apb_state_e state_reg;
  logic [3:0]     strb_next;
  logic           capture;
  logic           unused_bits;

  // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY get a zero-wait OKAY
  assign capture     = hsel & hready & htrans[1];
  assign unused_bits = ^{htrans[0], hprot[6:2]};

  ahb_strb_gen u_strb_gen (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .write   (hwrite),
    .strb    (strb_next)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      paddr     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= 4'h0;
      pprot     <= 3'b000;
    end else begin
      case (state_reg)
        IDLE, ERR2: begin
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          state_reg <= IDLE;
          if (capture) begin
            paddr     <= {haddr[ADDR_W-1:2], 2'b00};
            pwrite    <= hwrite;
            pstrb     <= strb_next;
            pprot     <= ahb_to_apb_prot(hprot);
            hreadyout <= 1'b0;
            if (!size_supported(hsize)) begin
              hresp     <= 1'b1;
              state_reg <= ERR1;
            end else if (hwrite) begin
              state_reg <= WDATA;
            end else begin
              psel      <= 1'b1;
              state_reg <= SETUP;
            end
          end
        end
        WDATA: begin
          // hwdata is only valid in the cycle after the address phase
          pwdata    <= hwdata;
          psel      <= 1'b1;
          state_reg <= SETUP;
        end
        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              hresp     <= 1'b1;
              state_reg <= ERR1;
            end else begin
              hreadyout <= 1'b1;
              if (!pwrite) hrdata <= prdata;
              state_reg <= IDLE;
            end
          end
        end
        ERR1: begin
          hreadyout <= 1'b1;
          state_reg <= ERR2;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb.sv
// Directed and random AHB transfers against a transaction-level model of the
// expected APB fields, response timing and read data.
module tb_ahb2apb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [6:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  // Only this slave sits on the bus, so bus HREADY follows its own hreadyout
  assign hready = hreadyout;

  ahb2apb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hsize(hsize), .hwrite(hwrite), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    hsel   = 1'b0;
    htrans = 2'b00;
    @(negedge clk);
  endtask

  // Issues the address phase in the current cycle, acts as the APB slave,
  // and returns at the negedge of the cycle where hreadyout is seen high.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [6:0] prot, input logic [31:0] wdata,
                      input int waitc, input logic err, input logic [31:0] rdata);
    int          cyc, acc, psel_cyc, nbytes, lane, exp_done;
    logic        bad, exp_err, stable_ok, prev_hresp;
    logic [31:0] exp_paddr;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_prot;

    bad       = (size > 3'd2);
    exp_err   = bad | err;
    exp_paddr = addr & 32'hFFFF_FFFC;
    exp_strb  = 4'h0;
    if (!bad && wr) begin
      nbytes   = 1 << size;
      lane     = (int'(addr[1:0]) / nbytes) * nbytes;
      exp_strb = 4'(((1 << nbytes) - 1) << lane);
    end
    // instruction access when data bit clear; always non-secure; privileged bit
    exp_prot = {!prot[0], 1'b1, prot[1]};
    exp_done = bad ? 2 : (3 + int'(wr) + waitc + int'(err));

    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr; hprot = prot;
    cyc = 0; acc = 0; psel_cyc = -1; stable_ok = 1'b1; prev_hresp = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
      end
      if (psel === 1'b1) begin
        if (psel_cyc < 0) begin
          psel_cyc = cyc;
          check("setup_penable", 32'(penable), 32'h0);
          check("paddr", paddr, exp_paddr);
          check("pwrite", 32'(pwrite), 32'(wr));
          check("pstrb", 32'(pstrb), 32'(exp_strb));
          check("pprot", 32'(pprot), 32'(exp_prot));
          if (wr) check("pwdata", pwdata, wdata);
        end else if (penable !== 1'b1 || paddr !== exp_paddr || pwrite !== wr ||
                     pstrb !== exp_strb || pprot !== exp_prot || (wr && pwdata !== wdata)) begin
          stable_ok = 1'b0;
        end
        if (penable === 1'b1) begin
          if (acc == waitc) begin
            pready = 1'b1; pslverr = err; prdata = rdata;
          end
          acc++;
        end
      end
      if (hreadyout === 1'b1) break;
      prev_hresp = hresp;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom();

    check("done_cycle", 32'(cyc), 32'(exp_done));
    check("hresp", 32'(hresp), 32'(exp_err));
    if (exp_err) check("err1_hresp", 32'(prev_hresp), 32'h1);
    check("psel_cycle", 32'(psel_cyc), bad ? 32'hFFFF_FFFF : (wr ? 32'd2 : 32'd1));
    if (!bad) check("apb_stable", 32'(stable_ok), 32'h1);
    if (!exp_err && !wr) last_rdata = rdata;
    check("hrdata", hrdata, last_rdata);
    $display("xfer addr=%08h wr=%0d size=%0d wait=%0d err=%0d -> cycles=%0d hresp=%0d hrdata=%08h",
             addr, wr, size, waitc, err, cyc, hresp, hrdata);
  endtask

  initial begin
    logic [2:0] rsize;
    int         r;

    rstn = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0; hwrite = 1'b0;
    hprot = '0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_psel_penable", 32'({psel, penable, pwrite}), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb_pprot", 32'({pstrb, pprot}), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    xfer(32'h4000_0008, 1'b0, 3'd2, 7'h03, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    idle_cycle();
    xfer(32'h4000_0003, 1'b1, 3'd0, 7'h01, 32'h1122_3344, 0, 1'b0, 32'h0);
    idle_cycle();
    xfer(32'h4000_0106, 1'b1, 3'd1, 7'h02, 32'hA5A5_5A5A, 1, 1'b0, 32'h0);
    idle_cycle();
    xfer(32'h4000_0104, 1'b0, 3'd2, 7'h00, 32'h0, 5, 1'b0, 32'h0BAD_F00D);
    idle_cycle();
    // slave error, then a transfer captured straight out of ERR2
    xfer(32'h4000_0200, 1'b1, 3'd2, 7'h03, 32'hCAFE_0001, 0, 1'b1, 32'h0);
    xfer(32'h4000_0204, 1'b0, 3'd2, 7'h03, 32'h0, 0, 1'b0, 32'h1357_9BDF);
    idle_cycle();
    xfer(32'h4000_0300, 1'b0, 3'b011, 7'h00, 32'h0, 0, 1'b0, 32'h0);
    xfer(32'h4000_0304, 1'b0, 3'd2, 7'h01, 32'h0, 0, 1'b0, 32'h2468_ACE0);
    // back-to-back reads issued in the completion cycle
    xfer(32'h4000_0400, 1'b0, 3'd2, 7'h01, 32'h0, 0, 1'b0, 32'h0000_0401);
    xfer(32'h4000_0404, 1'b0, 3'd2, 7'h01, 32'h0, 2, 1'b0, 32'h0000_0405);

    // BUSY with hsel high is a zero-wait OKAY
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h4000_0500; hsize = 3'd2; hwrite = 1'b0;
    @(negedge clk);
    check("busy_hreadyout", 32'(hreadyout), 32'h1);
    check("busy_hresp", 32'(hresp), 32'h0);
    check("busy_psel", 32'(psel), 32'h0);
    $display("busy cycle -> hreadyout=%0d hresp=%0d psel=%0d", hreadyout, hresp, psel);
    idle_cycle();

    // reset during ACCESS aborts the APB access
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0010; hsize = 3'd2; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check("pre_rst_access", 32'({psel, penable}), 32'h3);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_psel", 32'({psel, penable}), 32'h0);
    check("mid_rst_hreadyout", 32'(hreadyout), 32'h1);
    check("mid_rst_hrdata", hrdata, 32'h0);
    $display("reset in ACCESS -> psel=%0d hreadyout=%0d", psel, hreadyout);
    rstn = 1'b1;
    last_rdata = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      rsize = (r == 9) ? 3'($urandom_range(3, 7)) : 3'(r % 3);
      xfer(32'h4000_0000 | ($urandom() & 32'h0000_0FFF), 1'($urandom_range(0, 1)), rsize,
           7'($urandom_range(0, 127)), $urandom(), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), $urandom());
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
